// File: rtl/cmutex_merge_n_mem_pkg.sv
// merge_pkg: shared mode constants and index-width helper for the mutex merge.
package merge_pkg;
  localparam int MODE_STRICT = 0;
  localparam int MODE_ARB = 1;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cmutex_merge_n_mem_owner_fifo.sv
// owner_fifo: records the issuing channel of each outstanding token in issue order.
module owner_fifo import merge_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = idx_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_comb begin
    full = count == CW'(DEPTH);
    empty = count == '0;
    dout = mem[rp];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp == AW'(DEPTH - 1) ? '0 : wp + 1'b1;
      if (pop) rp <= rp == AW'(DEPTH - 1) ? '0 : rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
endmodule

// File: rtl/cmutex_merge_n_mem.sv
// cmutex_merge_n_mem: N-way drive/free merge with data, owner tracking and optional round-robin arbitration.
module cmutex_merge_n_mem import merge_pkg::*; #(
  parameter int N = 4,
  parameter int DW = 32,
  parameter int DEPTH = 2,
  parameter int MODE = MODE_STRICT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          i_drive,
  input  logic [N*DW-1:0]       i_data,
  output logic [N-1:0]          o_free,
  output logic                  o_driveNext,
  output logic [DW-1:0]         o_dataNext,
  output logic [idx_w(N)-1:0]   o_owner,
  input  logic                  i_freeNext,
  output logic                  o_err
);
  localparam int OW = idx_w(N);
  logic [N-1:0] busy, pend, fresh, req, win_oh, free_oh;
  logic [OW-1:0] rr, win, head;
  logic [DW-1:0] win_data;
  logic [DW-1:0] pdata [N];
  logic [$clog2(DEPTH):0] fifo_cnt;
  logic found, issue, pop, can_push, fifo_full, fifo_empty, err_now;
  int idx;
  always_comb begin
    pop = i_freeNext & (fifo_cnt != '0);
    can_push = ~fifo_full | pop;
    fresh = i_drive & ~busy & ~pend;
    req = fresh | pend;
    found = 1'b0;
    win = '0;
    idx = 0;
    // strict mode scans from 0 (lowest wins); arbitrated mode scans from rr
    for (int i = 0; i < N; i++) begin
      idx = MODE == MODE_ARB ? (int'(rr) + i) % N : i;
      if (!found && req[idx]) begin
        found = 1'b1;
        win = OW'(idx);
      end
    end
    issue = found & can_push;
    win_oh = issue ? N'(1) << win : '0;
    free_oh = pop ? N'(1) << head : '0;
    win_data = pend[win] ? pdata[win] : i_data[int'(win)*DW +: DW];
    err_now = (i_freeNext & fifo_empty) | (|(i_drive & busy)) |
              (MODE == MODE_ARB ? |(i_drive & pend) : ($countones(i_drive) > 1) | (found & ~can_push));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      pend <= '0;
      rr <= '0;
      o_free <= '0;
      o_driveNext <= 1'b0;
      o_dataNext <= '0;
      o_owner <= '0;
      o_err <= 1'b0;
    end else begin
      busy <= (busy | win_oh) & ~free_oh;
      pend <= MODE == MODE_ARB ? req & ~win_oh : '0;
      if (issue) rr <= int'(win) == N - 1 ? '0 : win + 1'b1;
      o_free <= free_oh;
      o_driveNext <= issue;
      if (issue) o_dataNext <= win_data;
      if (issue) o_owner <= win;
      o_err <= o_err | err_now;
    end
  end
  always_ff @(posedge clk)
    for (int k = 0; k < N; k++)
      if (fresh[k]) pdata[k] <= i_data[k*DW +: DW];
  owner_fifo #(.DEPTH(DEPTH), .W(OW)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(issue),
    .pop(pop),
    .din(win),
    .dout(head),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(fifo_cnt)
  );
endmodule

// File: tb/tb_cmutex_merge_n_mem.sv
// tb_cmutex_merge_n_mem: three configurations driven in parallel and checked against a queue-based model.
module tb_cmutex_merge_n_mem;
  logic clk = 0;
  logic rst_n = 0;
  logic [3:0] drive = 0;
  logic [127:0] data = 0;
  logic fr = 0;
  logic [2:0] od, oerr;
  logic [2:0][31:0] odat;
  logic [2:0][3:0] ofree;
  logic [2:0][1:0] oown;
  int vec = 0, fails = 0;
  int mode [3] = '{0, 1, 0};
  int depth [3] = '{2, 2, 1};
  int q [3][$];
  bit [3:0] mbusy [3], mpend [3];
  int mrr [3];
  bit [31:0] mpd [3][4];
  bit edrv [3], eerr [3];
  int eown [3];
  bit [31:0] edat [3];
  bit [3:0] efree [3];
  typedef struct {
    logic [3:0] d; logic [127:0] dat; logic f;
    logic edrv; logic [1:0] eown; logic [31:0] edat; logic [3:0] efree; logic eerr;
  } vec_t;
  vec_t tv [8];

  always #5 clk = ~clk;

  cmutex_merge_n_mem #(.N(4), .DW(32), .DEPTH(2), .MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .i_drive(drive),
    .i_data(data), .o_free(ofree[0]), .o_driveNext(od[0]), .o_dataNext(odat[0]), .o_owner(oown[0]),
    .i_freeNext(fr), .o_err(oerr[0]));
  cmutex_merge_n_mem #(.N(4), .DW(32), .DEPTH(2), .MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .i_drive(drive),
    .i_data(data), .o_free(ofree[1]), .o_driveNext(od[1]), .o_dataNext(odat[1]), .o_owner(oown[1]),
    .i_freeNext(fr), .o_err(oerr[1]));
  cmutex_merge_n_mem #(.N(4), .DW(32), .DEPTH(1), .MODE(0)) u2 (.clk(clk), .rst_n(rst_n), .i_drive(drive),
    .i_data(data), .o_free(ofree[2]), .o_driveNext(od[2]), .o_dataNext(odat[2]), .o_owner(oown[2]),
    .i_freeNext(fr), .o_err(oerr[2]));

  function automatic logic [127:0] pk(input int ch, input logic [31:0] v);
    logic [127:0] r = 0;
    r[ch*32 +: 32] = v;
    return r;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    vec++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      q[m].delete();
      mbusy[m] = 0; mpend[m] = 0; mrr[m] = 0;
      edrv[m] = 0; eerr[m] = 0; eown[m] = 0; edat[m] = 0; efree[m] = 0;
    end
  endtask

  task automatic model_step(input bit [3:0] d, input bit [127:0] dat, input bit f);
    for (int m = 0; m < 3; m++) begin
      bit p, room, e;
      int hd, w;
      bit [3:0] nw, rq;
      bit [31:0] wd;
      p = f && q[m].size() > 0;
      hd = p ? q[m][0] : 0;
      room = q[m].size() < depth[m] || p;
      e = (f && !p) || ((d & mbusy[m]) != 0);
      w = -1;
      wd = 0;
      if (mode[m] == 0) begin
        if ($countones(d) > 1) e = 1;
        for (int k = 0; k < 4; k++) if (w < 0 && d[k] && !mbusy[m][k]) w = k;
        if (w >= 0 && !room) begin e = 1; w = -1; end
        if (w >= 0) wd = dat[w*32 +: 32];
      end else begin
        if ((d & mpend[m]) != 0) e = 1;
        nw = d & ~mbusy[m] & ~mpend[m];
        for (int k = 0; k < 4; k++) if (nw[k]) mpd[m][k] = dat[k*32 +: 32];
        rq = nw | mpend[m];
        for (int i = 0; i < 4; i++) if (w < 0 && rq[(mrr[m] + i) % 4]) w = (mrr[m] + i) % 4;
        if (w >= 0 && !room) w = -1;
        mpend[m] = rq;
        if (w >= 0) begin
          mpend[m][w] = 0;
          mrr[m] = (w + 1) % 4;
          wd = mpd[m][w];
        end
      end
      edrv[m] = w >= 0;
      if (w >= 0) begin eown[m] = w; edat[m] = wd; end
      efree[m] = p ? 4'(1 << hd) : 4'h0;
      eerr[m] = eerr[m] | e;
      if (p) begin void'(q[m].pop_front()); mbusy[m][hd] = 0; end
      if (w >= 0) begin q[m].push_back(w); mbusy[m][w] = 1; end
    end
  endtask

  task automatic compare_all();
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("u%0d drive", m), od[m], edrv[m]);
      chk($sformatf("u%0d free", m), ofree[m], efree[m]);
      chk($sformatf("u%0d err", m), oerr[m], eerr[m]);
      chk($sformatf("u%0d data", m), odat[m], edat[m]);
      if (edrv[m]) chk($sformatf("u%0d owner", m), oown[m], eown[m]);
    end
  endtask

  task automatic cyc(input logic [3:0] d, input logic [127:0] dat, input logic f);
    @(negedge clk);
    drive = d; data = dat; fr = f;
    model_step(d, dat, f);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; drive = 0; data = 0; fr = 0;
    #1;
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("u%0d rst drive", m), od[m], 0);
      chk($sformatf("u%0d rst free", m), ofree[m], 0);
      chk($sformatf("u%0d rst err", m), oerr[m], 0);
      chk($sformatf("u%0d rst data", m), odat[m], 0);
      chk($sformatf("u%0d rst owner", m), oown[m], 0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    tv[0] = '{4'b0100, pk(2, 32'hA5), 0, 1, 2, 32'hA5, 4'b0000, 0};
    tv[1] = '{4'b0000, 128'h0, 1, 0, 0, 32'hA5, 4'b0100, 0};
    tv[2] = '{4'b0001, pk(0, 32'h11), 0, 1, 0, 32'h11, 4'b0000, 0};
    tv[3] = '{4'b1000, pk(3, 32'h33), 0, 1, 3, 32'h33, 4'b0000, 0};
    tv[4] = '{4'b0000, 128'h0, 1, 0, 0, 32'h33, 4'b0001, 0};
    tv[5] = '{4'b0000, 128'h0, 1, 0, 0, 32'h33, 4'b1000, 0};
    tv[6] = '{4'b0110, pk(1, 32'h22) | pk(2, 32'h44), 0, 1, 1, 32'h22, 4'b0000, 1};
    tv[7] = '{4'b0000, 128'h0, 1, 0, 0, 32'h22, 4'b0010, 1};
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(tv[i].d, tv[i].dat, tv[i].f);
      chk($sformatf("tv%0d drive", i), od[0], tv[i].edrv);
      if (tv[i].edrv) chk($sformatf("tv%0d owner", i), oown[0], tv[i].eown);
      chk($sformatf("tv%0d data", i), odat[0], tv[i].edat);
      chk($sformatf("tv%0d free", i), ofree[0], tv[i].efree);
      chk($sformatf("tv%0d err", i), oerr[0], tv[i].eerr);
    end
    do_reset();
    cyc(4'b1011, pk(0, 32'hC0) | pk(1, 32'hC1) | pk(3, 32'hC3), 0);
    chk("arb first owner", oown[1], 0);
    cyc(4'b0000, 128'h0, 0);
    chk("arb second drive", od[1], 1);
    chk("arb second owner", oown[1], 1);
    chk("arb second data", odat[1], 32'hC1);
    cyc(4'b0000, 128'h0, 1);
    chk("arb third drive", od[1], 1);
    chk("arb third owner", oown[1], 3);
    chk("arb third data", odat[1], 32'hC3);
    chk("arb err", oerr[1], 0);
    do_reset();
    cyc(4'b0001, pk(0, 32'h5), 0);
    cyc(4'b0010, pk(1, 32'h6), 1);
    chk("d1 pushpop drive", od[2], 1);
    chk("d1 pushpop owner", oown[2], 1);
    chk("d1 pushpop free", ofree[2], 4'b0001);
    chk("d1 pushpop err", oerr[2], 0);
    do_reset();
    cyc(4'b0100, pk(2, 32'h77), 0);
    do_reset();
    cyc(4'b0000, 128'h0, 1);
    chk("post-reset free", ofree[0], 0);
    chk("post-reset err", oerr[0], 1);
    for (int s = 0; s < 20; s++) begin
      do_reset();
      for (int c = 0; c < 30; c++) begin
        logic [3:0] d;
        logic [127:0] dat;
        for (int k = 0; k < 4; k++) begin
          d[k] = $urandom_range(0, 5) == 0;
          dat[k*32 +: 32] = $urandom;
        end
        cyc(d, dat, $urandom_range(0, 2) == 0);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end
endmodule
